// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the matrix keypad scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, column strobe constants and the row helpers
// used by the frame accumulator.
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_t;

  // Active-low one-hot column strobes, indexed by column select.
  localparam logic [3:0] KPCOL_C0 = 4'b1110;
  localparam logic [3:0] KPCOL_C1 = 4'b1101;
  localparam logic [3:0] KPCOL_C2 = 4'b1011;
  localparam logic [3:0] KPCOL_C3 = 4'b0111;

  // Frame accumulator hit counter values.
  localparam logic [1:0] HIT_NONE  = 2'd0;
  localparam logic [1:0] HIT_ONE   = 2'd1;
  localparam logic [1:0] HIT_MULTI = 2'd2;

  function automatic logic [3:0] col_decode(input logic [1:0] sel);
    logic [3:0] col;
    case (sel)
      2'd0:    col = KPCOL_C0;
      2'd1:    col = KPCOL_C1;
      2'd2:    col = KPCOL_C2;
      default: col = KPCOL_C3;
    endcase
    return col;
  endfunction

  // True when exactly one active-low row is asserted.
  function automatic logic single_low(input logic [3:0] rows);
    logic [3:0] act;
    act = ~rows;
    return (act != 4'd0) && ((act & (act - 4'd1)) == 4'd0);
  endfunction

  // Index of the single low row; only meaningful when single_low() is true.
  function automatic logic [1:0] row_index(input logic [3:0] rows);
    logic [1:0] idx;
    case (rows)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-event bundle between the scanner and the board/control side.
// Latency: n/a (wires only).
// Backpressure: none; keyValid is a fire-and-forget one-clock pulse.
//
// Signals:
//   kpRow    keypad rows, active-low, asynchronous to clk
//   kpCol    column strobes, active-low one-hot
//   keyCode  accepted key {rowIdx, colIdx}
//   keyValid one-clock pulse per accepted press
//   keyHeld  high while the accepted key is considered pressed
interface keypad_scanner_if;
  logic [3:0] kpRow;
  logic [3:0] kpCol;
  logic [3:0] keyCode;
  logic       keyValid;
  logic       keyHeld;

  // Scanner side.
  modport master (
    input  kpRow,
    output kpCol,
    output keyCode,
    output keyValid,
    output keyHeld
  );

  // Board pins / key consumer side.
  modport slave (
    output kpRow,
    input  kpCol,
    input  keyCode,
    input  keyValid,
    input  keyHeld
  );
endinterface

// File: rtl/keypad_scanner_tick_gen.sv
// Scan-rate tick generator: one-clock pulse every CLK_HZ/SCAN_HZ clocks.
// Latency: tick_o is registered, high the clock after the divider wraps.
// Backpressure: none; free-running.
//
// Ports:
//   clk     system clock
//   reset   synchronous, active-high
//   tick_o  one-clock scan tick
module scan_tick_gen #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);

  localparam int DIV   = (CLK_HZ / SCAN_HZ > 0) ? CLK_HZ / SCAN_HZ : 1;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic             wrap;

  assign wrap = (div_q == DIV_LAST);

  always_comb begin
    tick_d = wrap;
    div_d  = wrap ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobing, row sampling, frame-level debounce, key events.
// Latency: keyValid pulses the clock after the frame end completing the DEBOUNCE_SCANS-th matching frame.
// Backpressure: none; keyValid is a single-clock pulse that is not held or retried.
//
// Ports:
//   clk    system clock, single domain
//   reset  synchronous, active-high, overrides everything
//   kp     keypad_scanner_if.master: kpRow in, kpCol/keyCode/keyValid/keyHeld out
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int SCAN_HZ        = 1_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic              clk,
  input logic              reset,
  keypad_scanner_if.master kp
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] DB_TARGET = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] DB_FIRST  = CNT_W'(1);
  // With a single-frame debounce the first matching frame already decides.
  localparam logic FIRST_DECIDES = (DEBOUNCE_SCANS <= 1);

  logic tick;

  scan_tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .SCAN_HZ (SCAN_HZ)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .tick_o (tick)
  );

  // ---------------------------------------------------------------------------
  // Row synchronizer and column select
  // ---------------------------------------------------------------------------
  logic [3:0] rowsMeta_q, rowsSync_q;
  logic [1:0] colSel_q, colSel_d;

  always_comb begin
    colSel_d = tick ? colSel_q + 2'd1 : colSel_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rowsMeta_q <= 4'hF;
      rowsSync_q <= 4'hF;
      colSel_q   <= 2'd0;
    end else begin
      rowsMeta_q <= kp.kpRow;
      rowsSync_q <= rowsMeta_q;
      colSel_q   <= colSel_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame accumulator
  // ---------------------------------------------------------------------------
  logic [1:0] hitCnt_q, hitCnt_d;
  logic [3:0] hitCode_q, hitCode_d;
  logic       frame_end;
  logic       frame_hit;
  logic [3:0] frame_code;

  // hitCnt_d/hitCode_d fold the current column's sample into the frame, so
  // the frame-end decision includes column 3 without an extra cycle.
  always_comb begin
    hitCnt_d  = hitCnt_q;
    hitCode_d = hitCode_q;
    if (rowsSync_q != 4'hF) begin
      if (single_low(rowsSync_q) && (hitCnt_q == HIT_NONE)) begin
        hitCnt_d  = HIT_ONE;
        hitCode_d = {row_index(rowsSync_q), colSel_q};
      end else begin
        // A second hit in the frame or several rows at once: ambiguous, reject.
        hitCnt_d = HIT_MULTI;
      end
    end
  end

  assign frame_end  = tick && (colSel_q == 2'd3);
  assign frame_hit  = (hitCnt_d == HIT_ONE);
  assign frame_code = hitCode_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      hitCnt_q  <= HIT_NONE;
      hitCode_q <= 4'd0;
    end else if (tick) begin
      if (frame_end) begin
        hitCnt_q  <= HIT_NONE;
        hitCode_q <= 4'd0;
      end else begin
        hitCnt_q  <= hitCnt_d;
        hitCode_q <= hitCode_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM (advances only at frame end)
  // ---------------------------------------------------------------------------
  kp_state_t        state_q;
  logic [3:0]       cand_q;
  logic [CNT_W-1:0] dbCnt_q;
  logic [CNT_W-1:0] dbCnt_inc;
  logic [3:0]       keyCode_q;
  logic             keyValid_q;
  logic             keyHeld_q;
  logic             match_cand;
  logic             match_key;

  assign dbCnt_inc  = dbCnt_q + DB_FIRST;
  assign match_cand = frame_hit && (frame_code == cand_q);
  assign match_key  = frame_hit && (frame_code == keyCode_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cand_q     <= 4'd0;
      dbCnt_q    <= '0;
      keyCode_q  <= 4'd0;
      keyValid_q <= 1'b0;
      keyHeld_q  <= 1'b0;
    end else begin
      keyValid_q <= 1'b0;
      if (frame_end) begin
        case (state_q)
          ST_IDLE: begin
            if (frame_hit) begin
              cand_q <= frame_code;
              if (FIRST_DECIDES) begin
                state_q    <= ST_PRESSED;
                keyCode_q  <= frame_code;
                keyValid_q <= 1'b1;
                keyHeld_q  <= 1'b1;
                dbCnt_q    <= '0;
              end else begin
                state_q <= ST_DEBOUNCE;
                dbCnt_q <= DB_FIRST;
              end
            end
          end
          ST_DEBOUNCE: begin
            if (match_cand) begin
              if (dbCnt_inc >= DB_TARGET) begin
                state_q    <= ST_PRESSED;
                keyCode_q  <= cand_q;
                keyValid_q <= 1'b1;
                keyHeld_q  <= 1'b1;
                dbCnt_q    <= '0;
              end else begin
                dbCnt_q <= dbCnt_inc;
              end
            end else begin
              state_q <= ST_IDLE;
              dbCnt_q <= '0;
            end
          end
          ST_PRESSED: begin
            if (!match_key) begin
              if (FIRST_DECIDES) begin
                state_q   <= ST_IDLE;
                keyHeld_q <= 1'b0;
                dbCnt_q   <= '0;
              end else begin
                state_q <= ST_RELEASE;
                dbCnt_q <= DB_FIRST;
              end
            end
          end
          ST_RELEASE: begin
            if (match_key) begin
              // Glitch-length release: resume the press without a new event.
              state_q <= ST_PRESSED;
              dbCnt_q <= '0;
            end else if (dbCnt_inc >= DB_TARGET) begin
              state_q   <= ST_IDLE;
              keyHeld_q <= 1'b0;
              dbCnt_q   <= '0;
            end else begin
              dbCnt_q <= dbCnt_inc;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            dbCnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign kp.kpCol    = col_decode(colSel_q);
  assign kp.keyCode  = keyCode_q;
  assign kp.keyValid = keyValid_q;
  assign kp.keyHeld  = keyHeld_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad matrix model and a key-event scoreboard.
module tb_keypad_scanner;
  import keypad_scanner_pkg::*;

  localparam int CLK_HZ  = 1000;
  localparam int SCAN_HZ = 100;
  localparam int DB      = 2;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] press = 16'h0000;   // bit r*4+c = key at row r, column c pressed

  keypad_scanner_if kp_if();

  keypad_scanner #(
    .CLK_HZ         (CLK_HZ),
    .SCAN_HZ        (SCAN_HZ),
    .DEBOUNCE_SCANS (DB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp_if)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its row low while its column is strobed.
  always_comb begin
    logic [3:0] rows;
    rows = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (press[r*4+c] && !kp_if.kpCol[c]) rows[r] = 1'b0;
      end
    end
    kp_if.kpRow = rows;
  end

  typedef struct {
    logic [3:0] code;
    int         frame;
  } exp_t;

  exp_t       sb[$];
  int         total      = 0;
  int         bad        = 0;
  int         fe_cnt     = 0;
  int         pulses     = 0;
  logic [3:0] prev_col   = 4'b1110;
  logic       prev_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] code, input int frame);
    exp_t e;
    e.code  = code;
    e.frame = frame;
    sb.push_back(e);
  endtask

  // Advance one clock, sampling on the falling edge; tracks frame ends and
  // checks every keyValid pulse against the scoreboard.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    if (prev_col == 4'b0111 && kp_if.kpCol == 4'b1110) fe_cnt++;
    if (kp_if.keyValid) begin
      pulses++;
      chk("pulse_width", 32'(prev_valid), 32'd0);
      chk("pulse_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pulse_code", 32'(kp_if.keyCode), 32'(e.code));
        chk("pulse_frame", 32'(fe_cnt), 32'(e.frame));
        chk("pulse_held", 32'(kp_if.keyHeld), 32'd1);
      end
    end
    prev_col   = kp_if.kpCol;
    prev_valid = kp_if.keyValid;
  endtask

  task automatic wait_fe();
    int start;
    start = fe_cnt;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (fe_cnt != start) return;
    end
    chk("frame_timeout", 32'(fe_cnt), 32'(start + 1));
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) wait_fe();
  endtask

  initial begin
    logic [3:0] cur;
    int         n;

    // ---------------- reset, no keys ----------------
    reset = 1'b1;
    press = 16'h0000;
    repeat (3) cyc();
    chk("rst_kpCol",    32'(kp_if.kpCol),    32'hE);
    chk("rst_keyCode",  32'(kp_if.keyCode),  32'h0);
    chk("rst_keyValid", 32'(kp_if.keyValid), 32'h0);
    chk("rst_keyHeld",  32'(kp_if.keyHeld),  32'h0);
    reset = 1'b0;

    n = 0;
    while (kp_if.kpCol == 4'b1110 && n < 30) begin
      cyc();
      n++;
    end
    chk("col_first", 32'(kp_if.kpCol), 32'hD);
    for (int k = 0; k < 4; k++) begin
      cur = kp_if.kpCol;
      n = 0;
      do begin
        cyc();
        n++;
      end while (kp_if.kpCol == cur && n < 30);
      chk("col_dwell", 32'(n), 32'd10);
      chk("col_step", 32'(kp_if.kpCol), 32'({cur[2:0], cur[3]}));
    end
    chk("idle_no_pulse", 32'(pulses), 32'd0);

    // ---------------- clean press row1/col2 ----------------
    wait_fe();
    press = 16'h0040;
    push_exp(4'h6, fe_cnt + 2);
    frames(4);
    chk("clean_pulses", 32'(pulses), 32'd1);
    chk("clean_held",   32'(kp_if.keyHeld), 32'd1);
    chk("clean_code",   32'(kp_if.keyCode), 32'h6);
    press = 16'h0000;
    frames(2);
    chk("clean_release_held", 32'(kp_if.keyHeld), 32'd0);
    chk("clean_code_kept",    32'(kp_if.keyCode), 32'h6);
    frames(1);

    // ---------------- bounce: one frame only ----------------
    press = 16'h0040;
    frames(1);
    press = 16'h0000;
    frames(3);
    chk("bounce_pulses", 32'(pulses), 32'd1);
    chk("bounce_held",   32'(kp_if.keyHeld), 32'd0);

    // ---------------- ghost: r0c0 + r3c3 ----------------
    press = 16'h8001;
    frames(4);
    chk("ghost_pulses", 32'(pulses), 32'd1);
    chk("ghost_held",   32'(kp_if.keyHeld), 32'd0);
    press = 16'h0001;
    push_exp(4'h0, fe_cnt + 2);
    frames(3);
    chk("ghost_single_pulses", 32'(pulses), 32'd2);
    chk("ghost_single_held",   32'(kp_if.keyHeld), 32'd1);
    chk("ghost_single_code",   32'(kp_if.keyCode), 32'h0);
    press = 16'h0000;
    frames(3);
    chk("ghost_release_held", 32'(kp_if.keyHeld), 32'd0);

    // ---------------- release glitch, row2/col1 ----------------
    press = 16'h0200;
    push_exp(4'h9, fe_cnt + 2);
    frames(3);
    chk("glitch_pulses", 32'(pulses), 32'd3);
    press = 16'h0000;
    frames(1);
    chk("glitch_held_gap", 32'(kp_if.keyHeld), 32'd1);
    press = 16'h0200;
    frames(2);
    chk("glitch_held_back", 32'(kp_if.keyHeld), 32'd1);
    chk("glitch_no_repulse", 32'(pulses), 32'd3);
    press = 16'h0000;
    frames(2);
    chk("glitch_released", 32'(kp_if.keyHeld), 32'd0);
    frames(1);
    press = 16'h0200;
    push_exp(4'h9, fe_cnt + 2);
    frames(3);
    chk("repress_pulses", 32'(pulses), 32'd4);
    chk("repress_held",   32'(kp_if.keyHeld), 32'd1);
    press = 16'h0000;
    frames(3);
    chk("repress_release", 32'(kp_if.keyHeld), 32'd0);

    // ---------------- reset mid-debounce ----------------
    press = 16'h0040;
    frames(1);
    repeat (15) cyc();
    reset = 1'b1;
    cyc();
    chk("midrst_kpCol",    32'(kp_if.kpCol),    32'hE);
    chk("midrst_state",    32'(dut.state_q),    32'(ST_IDLE));
    chk("midrst_keyValid", 32'(kp_if.keyValid), 32'd0);
    chk("midrst_keyHeld",  32'(kp_if.keyHeld),  32'd0);
    chk("midrst_keyCode",  32'(kp_if.keyCode),  32'h0);
    reset = 1'b0;
    push_exp(4'h6, fe_cnt + 2);
    frames(3);
    chk("midrst_pulses", 32'(pulses), 32'd5);
    chk("midrst_held",   32'(kp_if.keyHeld), 32'd1);
    press = 16'h0000;
    frames(3);
    chk("midrst_release", 32'(kp_if.keyHeld), 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
